// File: rtl/col_merge_arbiter_if.sv
// Column-side and downstream-side signals of the column-merge readout stage.
// The slave modport is the arbiter view; master is the surrounding readout.
interface col_merge_arbiter_if #(
  parameter int unsigned NCOL      = 16,
  parameter int unsigned DATAWIDTH = 46,
  parameter int unsigned BCSTWIDTH = 27,
  parameter int unsigned CIDW      = 4
) ();
  logic                      arbMode;
  logic [NCOL-1:0]           colMask;
  logic [NCOL*DATAWIDTH-1:0] colData;
  logic [NCOL-1:0]           colHit;
  logic [NCOL-1:0]           colRead;
  logic [BCSTWIDTH-1:0]      colBCST;
  logic [DATAWIDTH+CIDW-1:0] dnData;
  logic                      dnUnreadHit;
  logic                      dnRead;
  logic [BCSTWIDTH-1:0]      dnBCST;
  logic [15:0]               wordCount;

  modport slave (
    input  arbMode, colMask, colData, colHit, dnRead, dnBCST,
    output colRead, colBCST, dnData, dnUnreadHit, wordCount
  );

  modport master (
    output arbMode, colMask, colData, colHit, dnRead, dnBCST,
    input  colRead, colBCST, dnData, dnUnreadHit, wordCount
  );
endinterface

// File: rtl/col_merge_arbiter.sv
// N-input column-merge arbiter (round-robin or fixed priority) feeding a small
// output FIFO of {colID, data} words, with a saturating word counter and BCST register.
module col_merge_arbiter #(
  parameter int unsigned NCOL      = 16,
  parameter int unsigned DATAWIDTH = 46,
  parameter int unsigned BCSTWIDTH = 27,
  parameter int unsigned CIDW      = 4,
  parameter int unsigned FIFODEPTH = 4
) (
  input logic                 clk,
  input logic                 reset,
  col_merge_arbiter_if.slave  bus_io
);

  localparam int unsigned PtrW  = $clog2(FIFODEPTH);
  localparam int unsigned WordW = DATAWIDTH + CIDW;
  localparam logic [PtrW:0]   FifoFull = (PtrW + 1)'(FIFODEPTH);
  localparam logic [CIDW-1:0] LastInit = CIDW'(NCOL - 1);

  logic [NCOL-1:0]  req;
  logic             grant_vld;
  logic [CIDW-1:0]  grant_idx;
  logic [NCOL-1:0]  grant_oh;
  logic [WordW-1:0] wr_data;
  logic             rd_en;

  logic [PtrW:0]    count_q, count_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CIDW-1:0]  last_grant_q, last_grant_d;
  logic [15:0]      word_cnt_q, word_cnt_d;
  logic [BCSTWIDTH-1:0] bcst_q;
  logic [WordW-1:0] mem_q [FIFODEPTH];

  assign req = bus_io.colHit & ~bus_io.colMask;

  always_comb begin
    int j;
    grant_vld = 1'b0;
    grant_idx = '0;
    j         = 0;
    if (bus_io.arbMode) begin
      for (int i = 0; i < int'(NCOL); i++) begin
        if (!grant_vld && req[i]) begin
          grant_vld = 1'b1;
          grant_idx = CIDW'(i);
        end
      end
    end else begin
      // Search starts one past the previous winner and wraps modulo NCOL.
      for (int k = 1; k <= int'(NCOL); k++) begin
        j = int'(last_grant_q) + k;
        if (j >= int'(NCOL)) j = j - int'(NCOL);
        if (!grant_vld && req[j]) begin
          grant_vld = 1'b1;
          grant_idx = CIDW'(j);
        end
      end
    end
    // Gating on the registered count keeps a full FIFO from ever being written.
    if (!reset || (count_q >= FifoFull)) grant_vld = 1'b0;
  end

  always_comb begin
    grant_oh = '0;
    if (grant_vld) grant_oh[grant_idx] = 1'b1;
  end

  always_comb begin
    int sel;
    sel     = int'(grant_idx) * int'(DATAWIDTH);
    wr_data = {grant_idx, bus_io.colData[sel +: DATAWIDTH]};
  end

  assign rd_en = bus_io.dnRead && (count_q != '0);

  always_comb begin
    count_d      = count_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    last_grant_d = last_grant_q;
    word_cnt_d   = word_cnt_q;
    if (grant_vld) begin
      wr_ptr_d     = wr_ptr_q + 1'b1;
      last_grant_d = grant_idx;
      if (word_cnt_q != 16'hFFFF) word_cnt_d = word_cnt_q + 16'd1;
    end
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({grant_vld, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      last_grant_q <= LastInit;
      word_cnt_q   <= '0;
      bcst_q       <= '0;
    end else begin
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      last_grant_q <= last_grant_d;
      word_cnt_q   <= word_cnt_d;
      bcst_q       <= bus_io.dnBCST;
    end
  end

  // Storage needs no reset; the output is gated while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (grant_vld) mem_q[wr_ptr_q] <= wr_data;
  end

  assign bus_io.colRead     = grant_oh;
  assign bus_io.dnUnreadHit = (count_q != '0);
  assign bus_io.dnData      = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign bus_io.wordCount   = word_cnt_q;
  assign bus_io.colBCST     = bcst_q;

endmodule
